multihot_encoder_seq: RTL and testbench

//  Parametrised sequential successor to the one-hot N-to-log2(N) encoder.
//  - Accepts a multi-hot request vector over a valid/ready handshake.
//  - Emits the index of every set bit, one per cycle, in a selectable priority order.
//  - Flags the last index of each vector, and flags all-zero vectors instead of leaving the output undefined.
//  - Sits between keypad/interrupt-style request sources and index consumers (decoders, muxes, FIFOs).

---
 rtl/encoder_pkg.sv | 22 ++
 rtl/ffs_index.sv | 38 +++
 rtl/multihot_encoder_seq.sv | 112 +++++++++++
 tb/tb_multihot_encoder_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the multi-hot encoder family: FSM state type and a
// constant-evaluable ceiling-log2 used to size index ports.
package encoder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Smallest r such that 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ffs_index.sv
// Combinational find-first-set. Returns the index of the highest-priority set
// bit and a one-hot mask selecting it. With LSB_FIRST=1 the lowest set bit
// wins, otherwise the highest. An all-zero vector yields idx=0, mask=0.
module ffs_index
  import encoder_pkg::*;
#(
  parameter int N         = 10,
  parameter bit LSB_FIRST = 1'b1,
  localparam int W        = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic [N-1:0] mask
);

  logic [N-1:0] ordered_s;
  logic [N-1:0] lowest_s;

  // Mirror the vector so priority is always "lowest set bit", isolate it with
  // the two's-complement trick, mirror back and binary-encode the one-hot mask.
  always_comb begin
    ordered_s = {N{1'b0}};
    lowest_s  = {N{1'b0}};
    mask      = {N{1'b0}};
    idx       = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      ordered_s[i] = LSB_FIRST ? vec[i] : vec[N-1-i];
    end
    lowest_s = ordered_s & (~ordered_s + N'(1));
    for (int i = 0; i < N; i++) begin
      mask[i] = LSB_FIRST ? lowest_s[i] : lowest_s[N-1-i];
    end
    for (int i = 0; i < N; i++) begin
      idx = idx | (mask[i] ? W'(i) : W'(0));
    end
  end

endmodule

// File: rtl/multihot_encoder_seq.sv
// Sequential multi-hot encoder: accepts a request vector over valid/ready and
// streams the index of every set bit, one per cycle, flagging the last one.
// All-zero vectors are reported with a one-cycle err_zero pulse instead.
// Outputs depend only on registered state, never combinationally on in_*.
module multihot_encoder_seq
  import encoder_pkg::*;
#(
  parameter int N         = 10,
  parameter bit LSB_FIRST = 1'b1,
  localparam int W        = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         err_zero,
  output logic         busy
);

  state_t       state_r;
  state_t       state_s;
  logic [N-1:0] pending_r;
  logic         err_zero_r;
  logic [N-1:0] sel_mask_s;
  logic [W-1:0] sel_idx_s;
  logic         single_s;
  logic         accept_s;
  logic         beat_s;

  ffs_index #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_ffs (
    .vec  (pending_r),
    .idx  (sel_idx_s),
    .mask (sel_mask_s)
  );

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == EMIT);
  assign busy      = (state_r == EMIT);
  assign out_idx   = sel_idx_s;
  assign err_zero  = err_zero_r;

  // At most one bit left; gated by EMIT so an empty pending never reads as last.
  assign single_s = ((pending_r & (pending_r - N'(1))) == {N{1'b0}});
  assign out_last = out_valid & single_s;

  assign accept_s = in_valid & in_ready;
  assign beat_s   = out_valid & out_ready;

  // Next-state logic: leave IDLE only for a non-empty vector, return after the last beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && (in_vec != {N{1'b0}})) begin
          state_s = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (out_ready && single_s) begin
          state_s = IDLE;
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; reset drops out_valid/busy immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pending vector: load on accept, clear the emitted bit on each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {N{1'b0}};
    end else if (accept_s) begin
      pending_r <= in_vec;
    end else if (beat_s) begin
      pending_r <= pending_r & ~sel_mask_s;
    end else begin
      pending_r <= pending_r;
    end
  end

  // One-cycle pulse following acceptance of an all-zero vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_zero_r <= 1'b0;
    end else begin
      err_zero_r <= accept_s && (in_vec == {N{1'b0}});
    end
  end

endmodule

// File: tb/tb_multihot_encoder_seq.sv
// Self-checking bench for multihot_encoder_seq. Three instances share the
// stimulus: N=10 LSB-first, N=10 MSB-first and N=16 LSB-first. The reference
// model lists the set bit positions of each vector in priority order and
// walks that list as beats are accepted.
module tb_multihot_encoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iv;
  logic [2:0] ir;
  logic [2:0] ov;
  logic [2:0] ol;
  logic [2:0] ez;
  logic [2:0] by;
  logic       ordy;
  logic [15:0] vec_bus;
  logic [3:0] oi [3];

  int compared   = 0;
  int mismatched = 0;

  int exp_list [3][16];
  int exp_len  [3];
  int exp_pos  [3];

  always #5 clk = ~clk;

  multihot_encoder_seq #(.N(10), .LSB_FIRST(1'b1)) u_lsb10 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_vec(vec_bus[9:0]),
    .out_valid(ov[0]), .out_ready(ordy), .out_idx(oi[0]), .out_last(ol[0]),
    .err_zero(ez[0]), .busy(by[0])
  );

  multihot_encoder_seq #(.N(10), .LSB_FIRST(1'b0)) u_msb10 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_vec(vec_bus[9:0]),
    .out_valid(ov[1]), .out_ready(ordy), .out_idx(oi[1]), .out_last(ol[1]),
    .err_zero(ez[1]), .busy(by[1])
  );

  multihot_encoder_seq #(.N(16), .LSB_FIRST(1'b1)) u_lsb16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_vec(vec_bus),
    .out_valid(ov[2]), .out_ready(ordy), .out_idx(oi[2]), .out_last(ol[2]),
    .err_zero(ez[2]), .busy(by[2])
  );

  // Expected emission order: set bit positions, ascending or descending.
  task automatic build_model(input logic [15:0] vec);
    for (int k = 0; k < 3; k++) begin
      int n;
      n = (k == 2) ? 16 : 10;
      exp_len[k] = 0;
      exp_pos[k] = 0;
      for (int i = 0; i < n; i++) begin
        int b;
        b = (k == 1) ? (n - 1 - i) : i;
        if (vec[b]) begin
          exp_list[k][exp_len[k]] = b;
          exp_len[k] = exp_len[k] + 1;
        end
      end
    end
  endtask

  function automatic bit any_pending();
    bit r;
    r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (exp_pos[k] < exp_len[k]) r = 1'b1;
    end
    return r;
  endfunction

  // Present one vector to all instances and follow every beat until drained.
  task automatic drain(input logic [15:0] vec, input int stall_first,
                       input int stall_pct, input string name);
    int c;
    build_model(vec);
    iv      = 3'b111;
    vec_bus = vec;
    ordy    = 1'b0;
    @(posedge clk); #1;
    c = 0;
    while ((c == 0 || any_pending()) && c < 400) begin
      ordy = (c < stall_first) ? 1'b0 : ($urandom_range(99) >= stall_pct);
      for (int k = 0; k < 3; k++) begin
        iv[k] = (exp_pos[k] < exp_len[k]) ? 1'($urandom_range(1)) : 1'b0;
      end
      vec_bus = 16'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        logic exp_ez;
        compared++;
        if (exp_pos[k] < exp_len[k]) begin
          logic exp_last;
          exp_last = (exp_pos[k] == exp_len[k] - 1) ? 1'b1 : 1'b0;
          if (ov[k] !== 1'b1 || ir[k] !== 1'b0 || by[k] !== 1'b1 ||
              oi[k] !== 4'(exp_list[k][exp_pos[k]]) || ol[k] !== exp_last) begin
            mismatched++;
            $display("FAIL %s inst%0d cycle%0d: valid=%b ready=%b busy=%b idx=%0d last=%b, required valid=1 ready=0 busy=1 idx=%0d last=%b",
                     name, k, c, ov[k], ir[k], by[k], oi[k], ol[k], exp_list[k][exp_pos[k]], exp_last);
          end
        end else begin
          if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || by[k] !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_idle inst%0d cycle%0d: valid=%b ready=%b busy=%b, required valid=0 ready=1 busy=0",
                     name, k, c, ov[k], ir[k], by[k]);
          end
        end
        exp_ez = (c == 0 && exp_len[k] == 0) ? 1'b1 : 1'b0;
        compared++;
        if (ez[k] !== exp_ez) begin
          mismatched++;
          $display("FAIL %s_err_zero inst%0d cycle%0d: err_zero=%b, required %b", name, k, c, ez[k], exp_ez);
        end
      end
      if (ordy) begin
        for (int k = 0; k < 3; k++) begin
          if (exp_pos[k] < exp_len[k]) exp_pos[k] = exp_pos[k] + 1;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    if (any_pending()) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: still draining after %0d cycles, required completion", name, c);
    end
    iv = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || ez[k] !== 1'b0 || by[k] !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_after inst%0d: valid=%b ready=%b err_zero=%b busy=%b, required 0 1 0 0",
                 name, k, ov[k], ir[k], ez[k], by[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string name);
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0 || oi[k] !== 4'd0 || ol[k] !== 1'b0 ||
          ez[k] !== 1'b0 || by[k] !== 1'b0) begin
        mismatched++;
        $display("FAIL %s inst%0d: ready=%b valid=%b idx=%0d last=%b err_zero=%b busy=%b, required 1 0 0 0 0 0",
                 name, k, ir[k], ov[k], oi[k], ol[k], ez[k], by[k]);
      end
    end
  endtask

  task automatic test_reset();
    check_idle_outputs("reset");
  endtask

  task automatic test_single_bit();
    drain(16'h0004, 0, 0, "single_bit");
  endtask

  task automatic test_multihot();
    drain(16'h0205, 0, 0, "multihot");
  endtask

  task automatic test_backpressure();
    drain(16'h0030, 3, 0, "backpressure");
  endtask

  task automatic test_zero_vector();
    drain(16'h0000, 0, 0, "zero_vector");
    // Upper bits exist only for the 16-wide instance.
    drain(16'hF000, 0, 0, "upper_bits");
  endtask

  task automatic test_n16_all_ones();
    drain(16'hFFFF, 0, 0, "n16_all_ones");
  endtask

  task automatic test_reset_mid_drain();
    iv      = 3'b111;
    vec_bus = 16'h03FF;
    ordy    = 1'b1;
    @(posedge clk); #1;
    iv = 3'b000;
    @(negedge clk);
    compared++;
    if (ov[0] !== 1'b1 || oi[0] !== 4'd0) begin
      mismatched++;
      $display("FAIL mid_drain_first: valid=%b idx=%0d, required valid=1 idx=0", ov[0], oi[0]);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_drain_async");
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_idle_outputs("mid_drain_after");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 40; t++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(5) == 0) v = v & 16'($urandom) & 16'($urandom);
      if ($urandom_range(9) == 0) v = 16'h0000;
      drain(v, $urandom_range(2), (t < 20) ? 0 : 40, "back_to_back");
    end
  endtask

  initial begin
    rst     = 1'b1;
    iv      = 3'b000;
    ordy    = 1'b0;
    vec_bus = 16'h0000;
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_single_bit();
    test_multihot();
    test_backpressure();
    test_zero_vector();
    test_n16_all_ones();
    test_reset_mid_drain();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
